regfile_wb_queue: RTL and testbench
===================================

Name: regfile_wb_queue

Overview:
- Write-side front end for the 32x32 register file (write port WE3/A3/WD3, read ports A1/RD1 and A2/RD2).
- Accepts writeback requests through a valid/ready handshake and buffers them in a small FIFO.
- Drains at most one entry per clock onto the register-file write port.
- Forwards still-pending values onto the two read paths, so decode never sees a stale register.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- ZERO_REG, 1, when 1, writes to address 0 are accepted and discarded, never enqueued or forwarded.

Ports:
- clk  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wb_valid  input  1  writeback request valid.
- wb_ready  output  1  queue can accept a request this cycle.
- wb_addr  input  5  destination register.
- wb_data  input  32  value to write.
- drain_en  input  1  permits a write to the register file this cycle.
- we3  output  1  register-file write enable.
- a3  output  5  register-file write address.
- wd3  output  32  register-file write data.
- a1  input  5  read address 1, shared with the register file.
- a2  input  5  read address 2, shared with the register file.
- rd1_rf  input  32  raw RD1 from the register file.
- rd2_rf  input  32  raw RD2 from the register file.
- rd1  output  32  forwarded read data 1.
- rd2  output  32  forwarded read data 2.
- count  output  clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset: while reset_n=0, the FIFO empties: read ptr=0, write ptr=0, count=0. This forces we3=0, a3=0, wd3=0 and wb_ready=1, and rd1/rd2 pass rd1_rf/rd2_rf through.
- Reset mid-operation: all pending entries are discarded and never written.
- Push: at a rising edge with wb_valid & wb_ready, {wb_addr, wb_data} goes to the tail.
  - With ZERO_REG=1 and wb_addr=0, the handshake still completes but nothing is stored.
- wb_ready = (count < DEPTH). It is registered-state based, not combinationally dependent on drain_en, so there is no pass-through when full.
- Drain:
  - we3 = drain_en & (count != 0).
  - a3/wd3 show the head entry. When the FIFO is empty they show 0.
  - At an edge with we3=1 the head pops; the register file captures the write on the same edge.
  - Minimum latency: accepted at edge N, written to the register file at edge N+1.
- Simultaneous push and pop: count unchanged and both pointers advance. This is legal at any count < DEPTH.
- When full, push is blocked. A pop in that cycle frees a slot, which becomes visible as wb_ready=1 in the next cycle.
- Pointers wrap modulo DEPTH. count is held separately, so full and empty are unambiguous.
- Forwarding (combinational):
  - rd1 = data of the youngest occupied entry whose addr == a1, else rd1_rf. rd2 likewise with a2.
  - The head entry being written this cycle is included, because the register file still shows the old value until the edge.
  - Duplicate addresses in the queue resolve to the youngest entry and are written in order, oldest first.
  - a1=0 or a2=0 with ZERO_REG=1 passes rd*_rf through unchanged.
  - A request presented on wb_* in the current cycle is not forwarded until it is stored.
- No combinational path from wb_valid to wb_ready, or from wb_* to rd1/rd2.

Test Plan:
- Reset/idle: reset_n=0 mid-stream with 3 entries queued -> immediately we3=0 and count=0. After release wb_ready=1 and rd1=rd1_rf; the 3 entries are never written.
- Single write: push (5, 0xDEADBEEF) at edge 0 with drain_en=1 -> at edge 1 we3=1, a3=5, wd3=0xDEADBEEF. Before edge 1, a1=5 gives rd1=0xDEADBEEF while rd1_rf=0.
- Fill and backpressure: drain_en=0, push 4 entries (regs 1..4, data 0x11..0x44) -> count=4, wb_ready=0, and a 5th request is held. Then drain_en=1 -> writes come out in order 1,2,3,4, one per cycle, and the 5th is accepted one cycle after the first pop.
- Duplicate forwarding: drain_en=0, push (7,0xA), (7,0xB), a2=7 -> rd2=0xB. Drain -> a3=7 with wd3=0xA, then a3=7 with wd3=0xB; rd2 returns to rd2_rf after the last pop.
- Zero register: push (0, 0xFFFFFFFF) -> handshake completes, count stays 0, we3 never asserts, a1=0 gives rd1=rd1_rf.
- Steady push+pop with wrap: push every cycle with drain_en=1 for 10 cycles -> count holds at 1 and wb_ready stays 1. The writes appear one cycle later in order across the pointer wrap, with no lost or duplicated writes.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the 32x32 register file: buffers writes, drains one per
// cycle onto WE3/A3/WD3, and forwards still-pending values onto both read paths.

module regfile_wb_queue_fwd_slot #(
  parameter int ZERO_REG = 1
) (
  input  logic       occ,
  input  logic [4:0] addr,
  input  logic [4:0] a1,
  input  logic [4:0] a2,
  output logic       hit1,
  output logic       hit2
);
  // Register 0 never matches when it is hardwired, even if a stale slot holds it.
  logic zero1, zero2;
  assign zero1 = (ZERO_REG != 0) && (a1 == 5'd0);
  assign zero2 = (ZERO_REG != 0) && (a2 == 5'd0);
  assign hit1  = occ && (addr == a1) && !zero1;
  assign hit2  = occ && (addr == a2) && !zero2;
endmodule

module regfile_wb_queue #(
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wb_valid,
  output logic                      wb_ready,
  input  logic [4:0]                wb_addr,
  input  logic [31:0]               wb_data,
  input  logic                      drain_en,
  output logic                      we3,
  output logic [4:0]                a3,
  output logic [31:0]               wd3,
  input  logic [4:0]                a1,
  input  logic [4:0]                a2,
  input  logic [31:0]               rd1_rf,
  input  logic [31:0]               rd2_rf,
  output logic [31:0]               rd1,
  output logic [31:0]               rd2,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][4:0]  addr_q;
  logic [DEPTH-1:0][31:0] data_q;
  logic [PW-1:0]          rptr, wptr;
  logic [CW-1:0]          cnt;
  logic                   push, pop, accept, empty;

  assign empty    = (cnt == '0);
  assign wb_ready = (cnt < CW'(DEPTH));
  assign accept   = wb_valid && wb_ready;
  // Writes to a hardwired zero register complete the handshake but are dropped here.
  assign push     = accept && !((ZERO_REG != 0) && (wb_addr == 5'd0));
  assign pop      = we3;

  assign we3   = drain_en && !empty;
  assign a3    = empty ? 5'd0  : addr_q[rptr];
  assign wd3   = empty ? 32'd0 : data_q[rptr];
  assign count = cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked entirely by cnt/rptr.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wptr] <= wb_addr;
      data_q[wptr] <= wb_data;
    end
  end

  logic [DEPTH-1:0] occ, hit1, hit2;

  genvar j;
  generate
    for (j = 0; j < DEPTH; j++) begin : g_slot
      logic [PW-1:0] age;
      assign age    = PW'(j) - rptr;
      assign occ[j] = ({1'b0, age} < cnt);
      regfile_wb_queue_fwd_slot #(.ZERO_REG(ZERO_REG)) u_slot (
        .occ  (occ[j]),
        .addr (addr_q[j]),
        .a1   (a1),
        .a2   (a2),
        .hit1 (hit1[j]),
        .hit2 (hit2[j])
      );
    end
  endgenerate

  // Walk slots oldest to youngest so the last hit (youngest) wins.
  always_comb begin
    logic [PW-1:0] idx;
    rd1 = rd1_rf;
    rd2 = rd2_rf;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + PW'(i);
      if (hit1[idx]) rd1 = data_q[idx];
      if (hit2[idx]) rd2 = data_q[idx];
    end
  end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: reset, single write, backpressure,
// duplicate forwarding, zero register and steady push+pop across pointer wrap.

module tb_regfile_wb_queue;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_valid, wb_ready, drain_en, we3;
  logic [4:0]  wb_addr, a3, a1, a2;
  logic [31:0] wb_data, wd3, rd1_rf, rd2_rf, rd1, rd2;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  regfile_wb_queue #(.DEPTH(4), .ZERO_REG(1)) dut (
    .clk(clk), .reset_n(reset_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .drain_en(drain_en), .we3(we3),
    .a3(a3), .wd3(wd3), .a1(a1), .a2(a2), .rd1_rf(rd1_rf), .rd2_rf(rd2_rf),
    .rd1(rd1), .rd2(rd2), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [4:0] ad, input logic [31:0] d);
    wb_valid = 1'b1; wb_addr = ad; wb_data = d;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; drain_en = 1'b0;
    a1 = 5'd0; a2 = 5'd0; rd1_rf = 32'h1234; rd2_rf = 32'h5678;
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(wb_ready), 32'd1);
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_a3", 32'(a3), 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_rd1", rd1, 32'h1234);
    @(negedge clk); reset_n = 1'b1;
    tick();

    // single write, minimum latency
    drain_en = 1'b1; a1 = 5'd5; rd1_rf = 32'd0;
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    #1 chk("single_nofwd_presented", rd1, 32'd0);
    tick(); wb_valid = 1'b0;
    chk("single_count", 32'(count), 32'd1);
    chk("single_we3", 32'(we3), 32'd1);
    chk("single_a3", 32'(a3), 32'd5);
    chk("single_wd3", wd3, 32'hDEADBEEF);
    chk("single_fwd_rd1", rd1, 32'hDEADBEEF);
    tick();
    chk("single_drained", 32'(count), 32'd0);
    chk("single_we3_off", 32'(we3), 32'd0);
    chk("single_rd1_rf", rd1, 32'd0);

    // fill and backpressure
    drain_en = 1'b0;
    push_one(5'd1, 32'h11); push_one(5'd2, 32'h22);
    push_one(5'd3, 32'h33); push_one(5'd4, 32'h44);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(wb_ready), 32'd0);
    chk("full_we3", 32'(we3), 32'd0);
    a1 = 5'd3; #1 chk("full_fwd_rd1", rd1, 32'h33);
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    tick();
    chk("full_held", 32'(count), 32'd4);
    drain_en = 1'b1; #1;
    chk("drain1_we3", 32'(we3), 32'd1);
    chk("drain1_a3", 32'(a3), 32'd1);
    chk("drain1_wd3", wd3, 32'h11);
    chk("drain1_ready_still0", 32'(wb_ready), 32'd0);
    tick();
    chk("drain2_a3", 32'(a3), 32'd2);
    chk("drain2_count", 32'(count), 32'd3);
    chk("drain2_ready", 32'(wb_ready), 32'd1);
    tick(); wb_valid = 1'b0;
    chk("drain3_a3", 32'(a3), 32'd3);
    chk("drain3_count", 32'(count), 32'd3);
    tick();
    chk("drain4_a3", 32'(a3), 32'd4);
    chk("drain4_wd3", wd3, 32'h44);
    tick();
    chk("drain5_a3", 32'(a3), 32'd9);
    chk("drain5_wd3", wd3, 32'h99);
    chk("drain5_count", 32'(count), 32'd1);
    tick();
    chk("drain_empty", 32'(count), 32'd0);
    chk("drain_empty_a3", 32'(a3), 32'd0);

    // reset mid-stream discards pending entries
    drain_en = 1'b0;
    push_one(5'd10, 32'hA0); push_one(5'd11, 32'hA1); push_one(5'd12, 32'hA2);
    chk("pre_rst_count", 32'(count), 32'd3);
    drain_en = 1'b1; a1 = 5'd10; rd1_rf = 32'hCAFE;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_we3", 32'(we3), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(wb_ready), 32'd1);
    chk("post_rst_rd1", rd1, 32'hCAFE);
    tick();
    chk("post_rst_no_write", 32'(we3), 32'd0);

    // duplicate addresses: youngest forwarded, written oldest first
    drain_en = 1'b0; a2 = 5'd7; rd2_rf = 32'h5555;
    push_one(5'd7, 32'hA); push_one(5'd7, 32'hB);
    chk("dup_rd2", rd2, 32'hB);
    drain_en = 1'b1; #1;
    chk("dup_first_a3", 32'(a3), 32'd7);
    chk("dup_first_wd3", wd3, 32'hA);
    tick();
    chk("dup_second_wd3", wd3, 32'hB);
    chk("dup_rd2_last", rd2, 32'hB);
    tick();
    chk("dup_rd2_rf", rd2, 32'h5555);
    chk("dup_count", 32'(count), 32'd0);

    // zero register dropped
    a1 = 5'd0; rd1_rf = 32'h0BAD;
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    #1 chk("zero_ready", 32'(wb_ready), 32'd1);
    tick(); wb_valid = 1'b0;
    chk("zero_count", 32'(count), 32'd0);
    chk("zero_we3", 32'(we3), 32'd0);
    chk("zero_rd1", rd1, 32'h0BAD);

    // steady push+pop across wrap
    drain_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wb_valid = 1'b1; wb_addr = 5'(20 + k); wb_data = 32'(k * 32'h101);
      tick();
      chk($sformatf("steady%0d_count", k), 32'(count), 32'd1);
      chk($sformatf("steady%0d_ready", k), 32'(wb_ready), 32'd1);
      chk($sformatf("steady%0d_a3", k), 32'(a3), 32'(20 + k));
      chk($sformatf("steady%0d_wd3", k), wd3, 32'(k * 32'h101));
    end
    wb_valid = 1'b0;
    tick();
    chk("steady_end_count", 32'(count), 32'd0);
    chk("steady_end_we3", 32'(we3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
